// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, LSU-busy stalls and redirect/trap
// flush sequencing, plus a saturating counter of front-end stall cycles.
module pipe_hazard_ctrl #(
  parameter int REG_ADDRW = 5,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_id_valid,
  input  logic [REG_ADDRW-1:0] i_id_rs1id,
  input  logic [REG_ADDRW-1:0] i_id_rs2id,
  input  logic                 i_id_rs1en,
  input  logic                 i_id_rs2en,
  input  logic                 i_ex_valid,
  input  logic [REG_ADDRW-1:0] i_ex_rdid,
  input  logic                 i_ex_lden,
  input  logic                 i_mem_busy,
  input  logic                 i_redirect,
  input  logic                 i_trap,
  input  logic                 i_cnt_clr,
  output logic                 o_if_stall,
  output logic                 o_id_stall,
  output logic                 o_ex_stall,
  output logic                 o_idex_bubble,
  output logic                 o_flush,
  output logic [1:0]           o_state,
  output logic [CNT_W-1:0]     o_stall_cnt
);

  // state      | meaning
  // S_RUN      | normal issue; resolves flush, mem stall and load-use
  // S_MEM_WAIT | LSU busy, whole front end held; flush requests deferred
  // S_FLUSH    | remaining flush cycles after the redirect/trap cycle
  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);
  localparam logic [1:0] S_AFTER_EV = (FLUSH_CYC > 1) ? S_FLUSH : S_RUN;

  logic [1:0]       r_state;
  logic [3:0]       r_fcnt;
  logic             r_pend;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [1:0] w_state_nxt;
  logic [3:0] w_fcnt_nxt;
  logic       w_pend_nxt;
  logic       w_load_use;
  logic       w_ev;
  logic       w_if_stall;
  logic       w_id_stall;
  logic       w_ex_stall;
  logic       w_bubble;
  logic       w_flush;

  assign w_load_use = i_id_valid & i_ex_valid & i_ex_lden & (i_ex_rdid != '0) &
                      ((i_id_rs1en & (i_id_rs1id == i_ex_rdid)) |
                       (i_id_rs2en & (i_id_rs2id == i_ex_rdid)));
  assign w_ev = i_trap | i_redirect;

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_pend_nxt  = r_pend;
    w_if_stall  = 1'b0;
    w_id_stall  = 1'b0;
    w_ex_stall  = 1'b0;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_ev | r_pend) begin
          w_flush     = 1'b1;
          w_fcnt_nxt  = FLUSH_LOAD;
          w_pend_nxt  = 1'b0;
          w_state_nxt = S_AFTER_EV;
        end else if (i_mem_busy) begin
          w_if_stall  = 1'b1;
          w_id_stall  = 1'b1;
          w_ex_stall  = 1'b1;
          w_state_nxt = S_MEM_WAIT;
        end else if (w_load_use) begin
          w_if_stall = 1'b1;
          w_id_stall = 1'b1;
          w_bubble   = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        // Flushing here would discard the access still in flight; remember it instead.
        if (w_ev) w_pend_nxt = 1'b1;
        if (i_mem_busy) begin
          w_if_stall = 1'b1;
          w_id_stall = 1'b1;
          w_ex_stall = 1'b1;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_FLUSH: begin
        w_flush = 1'b1;
        if (w_ev) begin
          w_fcnt_nxt = FLUSH_LOAD;
        end else if (r_fcnt <= 4'd1) begin
          w_fcnt_nxt  = 4'd0;
          w_state_nxt = S_RUN;
        end else begin
          w_fcnt_nxt = r_fcnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_fcnt_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
      r_fcnt  <= 4'd0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_if_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_if_stall    = w_if_stall;
  assign o_id_stall    = w_id_stall;
  assign o_ex_stall    = w_ex_stall;
  assign o_idex_bubble = w_bubble;
  assign o_flush       = w_flush;
  assign o_state       = r_state;
  assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FLUSH_CYC=2, CNT_W=4) with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_id_valid;
  logic [4:0] i_id_rs1id;
  logic [4:0] i_id_rs2id;
  logic       i_id_rs1en;
  logic       i_id_rs2en;
  logic       i_ex_valid;
  logic [4:0] i_ex_rdid;
  logic       i_ex_lden;
  logic       i_mem_busy;
  logic       i_redirect;
  logic       i_trap;
  logic       i_cnt_clr;
  logic       o_if_stall;
  logic       o_id_stall;
  logic       o_ex_stall;
  logic       o_idex_bubble;
  logic       o_flush;
  logic [1:0] o_state;
  logic [3:0] o_stall_cnt;

  int n_total;
  int n_pass;

  pipe_hazard_ctrl #(.REG_ADDRW(5), .FLUSH_CYC(2), .CNT_W(4)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_valid(i_id_valid), .i_id_rs1id(i_id_rs1id), .i_id_rs2id(i_id_rs2id),
    .i_id_rs1en(i_id_rs1en), .i_id_rs2en(i_id_rs2en),
    .i_ex_valid(i_ex_valid), .i_ex_rdid(i_ex_rdid), .i_ex_lden(i_ex_lden),
    .i_mem_busy(i_mem_busy), .i_redirect(i_redirect), .i_trap(i_trap),
    .i_cnt_clr(i_cnt_clr),
    .o_if_stall(o_if_stall), .o_id_stall(o_id_stall), .o_ex_stall(o_ex_stall),
    .o_idex_bubble(o_idex_bubble), .o_flush(o_flush), .o_state(o_state),
    .o_stall_cnt(o_stall_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Stall/flush outputs packed as {if, id, ex, bubble, flush}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, o_if_stall, o_id_stall, o_ex_stall, o_idex_bubble, o_flush}, {27'd0, exp});
  endtask

  task automatic idle();
    i_id_valid = 0; i_id_rs1id = 0; i_id_rs2id = 0; i_id_rs1en = 0; i_id_rs2en = 0;
    i_ex_valid = 0; i_ex_rdid = 0; i_ex_lden = 0;
    i_mem_busy = 0; i_redirect = 0; i_trap = 0; i_cnt_clr = 0;
  endtask

  task automatic load_use(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic en1, input logic en2, input logic [4:0] rd);
    i_id_valid = 1; i_id_rs1id = rs1; i_id_rs2id = rs2; i_id_rs1en = en1; i_id_rs2en = en2;
    i_ex_valid = 1; i_ex_rdid = rd; i_ex_lden = 1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    idle();
    i_rst_n = 0;
    #12;
    chk_ctl("reset_ctl", 5'b00000);
    chk("reset_state", {30'd0, o_state}, 32'd0);
    chk("reset_cnt", {28'd0, o_stall_cnt}, 32'd0);
    i_rst_n = 1;

    // lw x5 in EX, add x6,x5,x1 in ID
    load_use(5'd5, 5'd1, 1, 1, 5'd5);
    #1 chk_ctl("lu_rs1", 5'b11010);
    chk("lu_rs1_state", {30'd0, o_state}, 32'd0);
    tick();
    i_ex_valid = 0;
    #1 chk_ctl("lu_after", 5'b00000);
    chk("lu_cnt1", {28'd0, o_stall_cnt}, 32'd1);
    load_use(5'd2, 5'd7, 1, 1, 5'd7);
    #1 chk_ctl("lu_rs2", 5'b11010);
    tick();
    load_use(5'd2, 5'd7, 1, 0, 5'd7);
    #1 chk_ctl("lu_rs2_noen", 5'b00000);
    load_use(5'd0, 5'd0, 1, 1, 5'd0);
    #1 chk_ctl("lu_x0", 5'b00000);
    load_use(5'd5, 5'd1, 1, 1, 5'd5);
    i_ex_lden = 0;
    #1 chk_ctl("lu_noload", 5'b00000);
    tick();
    chk("lu_cnt2", {28'd0, o_stall_cnt}, 32'd2);

    // single redirect: flush 2 cycles, states 0,2,0
    idle();
    i_redirect = 1;
    #1 chk_ctl("rd_c0", 5'b00001);
    chk("rd_c0_state", {30'd0, o_state}, 32'd0);
    tick();
    i_redirect = 0;
    #1 chk_ctl("rd_c1", 5'b00001);
    chk("rd_c1_state", {30'd0, o_state}, 32'd2);
    tick();
    #1 chk_ctl("rd_c2", 5'b00000);
    chk("rd_c2_state", {30'd0, o_state}, 32'd0);

    // trap during FLUSH restarts the sequence
    i_redirect = 1;
    tick();
    i_redirect = 0; i_trap = 1;
    #1 chk_ctl("rl_c1", 5'b00001);
    tick();
    i_trap = 0;
    #1 chk_ctl("rl_c2", 5'b00001);
    chk("rl_c2_state", {30'd0, o_state}, 32'd2);
    tick();
    #1 chk_ctl("rl_c3", 5'b00000);
    chk("rl_c3_state", {30'd0, o_state}, 32'd0);

    // redirect beats mem_busy and load-use
    load_use(5'd5, 5'd1, 1, 1, 5'd5);
    i_redirect = 1; i_mem_busy = 1;
    #1 chk_ctl("prio", 5'b00001);
    tick();
    idle();
    tick();
    chk("prio_state", {30'd0, o_state}, 32'd0);
    chk("prio_cnt", {28'd0, o_stall_cnt}, 32'd2);

    // mem_busy 4 cycles, trap on cycle 2 deferred until RUN
    i_mem_busy = 1;
    #1 chk_ctl("mw_c1", 5'b11100);
    chk("mw_c1_state", {30'd0, o_state}, 32'd0);
    tick();
    i_trap = 1;
    #1 chk_ctl("mw_c2", 5'b11100);
    chk("mw_c2_state", {30'd0, o_state}, 32'd1);
    tick();
    i_trap = 0;
    load_use(5'd5, 5'd1, 1, 1, 5'd5);
    #1 chk_ctl("mw_c3", 5'b11100);
    tick();
    idle();
    i_mem_busy = 1;
    #1 chk_ctl("mw_c4", 5'b11100);
    tick();
    i_mem_busy = 0;
    #1 chk_ctl("mw_c5", 5'b00000);
    chk("mw_c5_state", {30'd0, o_state}, 32'd1);
    tick();
    #1 chk_ctl("mw_c6", 5'b00001);
    chk("mw_c6_state", {30'd0, o_state}, 32'd0);
    tick();
    #1 chk_ctl("mw_c7", 5'b00001);
    chk("mw_c7_state", {30'd0, o_state}, 32'd2);
    tick();
    #1 chk_ctl("mw_c8", 5'b00000);
    chk("mw_cnt", {28'd0, o_stall_cnt}, 32'd6);

    // saturation with CNT_W=4
    i_rst_n = 0;
    #1 chk("sat_rst", {28'd0, o_stall_cnt}, 32'd0);
    i_rst_n = 1;
    i_mem_busy = 1;
    for (int i = 0; i < 15; i++) tick();
    chk("sat_15", {28'd0, o_stall_cnt}, 32'd15);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_hold", {28'd0, o_stall_cnt}, 32'd15);
    i_mem_busy = 0;
    tick();
    i_mem_busy = 1; i_cnt_clr = 1;
    #1 chk_ctl("clr_stall", 5'b11100);
    tick();
    i_cnt_clr = 0;
    chk("clr_wins", {28'd0, o_stall_cnt}, 32'd0);
    tick();
    chk("clr_then_inc", {28'd0, o_stall_cnt}, 32'd1);

    // async reset inside MEM_WAIT with a pending trap
    i_trap = 1;
    tick();
    i_trap = 0;
    chk("ar_pre_state", {30'd0, o_state}, 32'd1);
    i_rst_n = 0;
    #1 chk("ar_state", {30'd0, o_state}, 32'd0);
    chk("ar_cnt", {28'd0, o_stall_cnt}, 32'd0);
    i_mem_busy = 0;
    #1 i_rst_n = 1;
    #1 chk_ctl("ar_post_run", 5'b00000);
    tick();
    #1 chk_ctl("ar_no_pend", 5'b00000);
    chk("ar_post_state", {30'd0, o_state}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
